// File: rtl/tr_step_tracker.sv
// Tracking-mode stepper controller: position error -> step period -> step/dir/enable pins.
// Two-stage error/period pipeline feeding a four-state tracker with an internal pulse generator.
module tr_step_tracker #(
  parameter int WIDTH_IN    = 12,
  parameter int WIDTH_WORK  = 16,
  parameter int K_WIDTH     = 20,
  parameter int FRAC_BITS   = 4,
  parameter int N_MIN       = 128,
  parameter int PULSE_WIDTH = 50,
  parameter int DIR_SETUP   = 100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_valid,
  input  logic                  tr_mode_enable,
  input  logic [WIDTH_IN-1:0]   x0,
  input  logic [WIDTH_WORK-1:0] x,
  input  logic [WIDTH_WORK-1:0] dx1,
  input  logic [WIDTH_WORK-1:0] dx2,
  input  logic [WIDTH_WORK-1:0] F1,
  input  logic [WIDTH_WORK-1:0] F2,
  input  logic [K_WIDTH-1:0]    k,
  input  logic [WIDTH_WORK-1:0] dz_in,
  input  logic [WIDTH_WORK-1:0] dz_out,
  output logic [WIDTH_WORK-1:0] N,
  output logic                  drv_step,
  output logic                  drv_dir,
  output logic                  drv_enable_SM,
  output logic [WIDTH_WORK-1:0] step_cnt
);

  localparam int PROD_W = K_WIDTH + WIDTH_WORK;
  localparam int PW_W   = $clog2(PULSE_WIDTH + 1);
  localparam int DS_W   = $clog2(DIR_SETUP + 1);
  localparam logic [WIDTH_WORK-1:0] N_MIN_W = WIDTH_WORK'(N_MIN);
  localparam logic [PW_W-1:0]       PW_LD   = PW_W'(PULSE_WIDTH - 1);
  localparam logic [DS_W-1:0]       DS_LD   = DS_W'(DIR_SETUP - 1);

  typedef enum logic [1:0] {IDLE, TO_ZERO, IN_DZ, DIR_CHANGE} state_t;

  logic [WIDTH_WORK-1:0] x0_ext;
  logic [WIDTH_WORK-1:0] dx_d, dx_q, n_d, n_q, n_lin, p_eff;
  logic                  sgn_d, sgn_q, vld_d, vld_q;
  logic [WIDTH_WORK-1:0] lin_diff;
  logic [PROD_W-1:0]     lin_prod;
  logic [PROD_W:0]       lin_sum;

  state_t                st_d, st_q;
  logic                  step_d, step_q, dir_d, dir_q, en_d, en_q;
  logic [WIDTH_WORK-1:0] scnt_d, scnt_q, per_d, per_q;
  logic [PW_W-1:0]       pw_d, pw_q;
  logic [DS_W-1:0]       dw_d, dw_q;

  assign x0_ext = {{(WIDTH_WORK-WIDTH_IN){1'b0}}, x0};

  // Stage 1: magnitude/sign of the error, held between strobes.
  always_comb begin
    dx_d  = dx_q;
    sgn_d = sgn_q;
    vld_d = data_valid;
    if (data_valid) begin
      if (x <= x0_ext) begin
        dx_d  = x0_ext - x;
        sgn_d = 1'b1;
      end else begin
        dx_d  = x - x0_ext;
        sgn_d = 1'b0;
      end
    end
  end

  // Stage 2: piecewise-linear period law, recomputed only on a fresh sample.
  always_comb begin
    lin_diff = dx_q - dx1;
    lin_prod = PROD_W'(k) * PROD_W'(lin_diff);
    lin_sum  = {1'b0, lin_prod >> FRAC_BITS} + {{(PROD_W+1-WIDTH_WORK){1'b0}}, F1};
    n_lin    = (|lin_sum[PROD_W:WIDTH_WORK]) ? '1 : lin_sum[WIDTH_WORK-1:0];
    n_d      = n_q;
    if (vld_q) begin
      if (dx_q >= dx2)      n_d = F2;
      else if (dx_q >= dx1) n_d = n_lin;
      else                  n_d = F1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dx_q  <= '0;
      sgn_q <= 1'b0;
      vld_q <= 1'b0;
      n_q   <= '0;
    end else begin
      dx_q  <= dx_d;
      sgn_q <= sgn_d;
      vld_q <= vld_d;
      n_q   <= n_d;
    end
  end

  assign p_eff = (n_q < N_MIN_W) ? N_MIN_W : n_q;

  always_comb begin
    st_d   = st_q;
    step_d = step_q;
    dir_d  = dir_q;
    en_d   = en_q;
    scnt_d = scnt_q;
    per_d  = per_q;
    pw_d   = pw_q;
    dw_d   = dw_q;
    if (per_q != '0) per_d = per_q - 1'b1;
    if (step_q) begin
      if (pw_q == '0) step_d = 1'b0;
      else            pw_d   = pw_q - 1'b1;
    end
    if (!tr_mode_enable) begin
      st_d   = IDLE;
      step_d = 1'b0;
      en_d   = 1'b0;
    end else begin
      case (st_q)
        IDLE: begin
          st_d   = TO_ZERO;
          scnt_d = '0;
          dir_d  = sgn_q;
          en_d   = 1'b1;
          per_d  = '0;
        end
        TO_ZERO: begin
          if (dx_q <= dz_in) begin
            st_d   = IN_DZ;
            en_d   = 1'b0;
            step_d = 1'b0;
          end else if (sgn_q != dir_q) begin
            st_d = DIR_CHANGE;
            dw_d = DS_LD;
          end else if (per_q == '0) begin
            step_d = 1'b1;
            pw_d   = PW_LD;
            per_d  = p_eff - 1'b1;
            scnt_d = scnt_q + 1'b1;
          end
        end
        IN_DZ: begin
          if (dx_q >= dz_out) begin
            en_d  = 1'b1;
            per_d = '0;
            if (sgn_q == dir_q) begin
              st_d = TO_ZERO;
            end else begin
              st_d = DIR_CHANGE;
              dw_d = DS_LD;
            end
          end
        end
        DIR_CHANGE: begin
          // Dwell only starts counting once the in-flight pulse has dropped.
          if (step_q) begin
            dw_d = DS_LD;
          end else if (dw_q == '0) begin
            dir_d = sgn_q;
            st_d  = TO_ZERO;
            per_d = '0;
          end else begin
            dw_d = dw_q - 1'b1;
          end
        end
        default: st_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= IDLE;
      step_q <= 1'b0;
      dir_q  <= 1'b0;
      en_q   <= 1'b0;
      scnt_q <= '0;
      per_q  <= '0;
      pw_q   <= '0;
      dw_q   <= '0;
    end else begin
      st_q   <= st_d;
      step_q <= step_d;
      dir_q  <= dir_d;
      en_q   <= en_d;
      scnt_q <= scnt_d;
      per_q  <= per_d;
      pw_q   <= pw_d;
      dw_q   <= dw_d;
    end
  end

  assign N             = n_q;
  assign drv_step      = step_q;
  assign drv_dir       = dir_q;
  assign drv_enable_SM = en_q;
  assign step_cnt      = scnt_q;

endmodule

// File: tb/tb_tr_step_tracker.sv
// Directed bench for tr_step_tracker: rate law, pulse timing, deadzone, direction dwell, enable/reset.
module tb_tr_step_tracker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        data_valid = 1'b0;
  logic        tr_mode_enable = 1'b0;
  logic [11:0] x0;
  logic [15:0] x, dx1, dx2, F1, F2, dz_in, dz_out;
  logic [19:0] k;
  logic [15:0] N, step_cnt;
  logic        drv_step, drv_dir, drv_enable_SM;

  int errors = 0;
  int checks = 0;
  int cyc_no = 0;

  always #5 clk = ~clk;

  tr_step_tracker dut (
    .clk(clk), .rst(rst), .data_valid(data_valid), .tr_mode_enable(tr_mode_enable),
    .x0(x0), .x(x), .dx1(dx1), .dx2(dx2), .F1(F1), .F2(F2), .k(k),
    .dz_in(dz_in), .dz_out(dz_out), .N(N), .drv_step(drv_step), .drv_dir(drv_dir),
    .drv_enable_SM(drv_enable_SM), .step_cnt(step_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc_no++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [15:0] xv);
    x = xv;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
  endtask

  task automatic wait_rise(input int bound, output int at);
    logic prev;
    prev = drv_step;
    at = -1;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (!prev && drv_step) begin
        at = cyc_no;
        break;
      end
      prev = drv_step;
    end
  endtask

  // which: 0 = drv_step, 1 = drv_dir
  task automatic wait_sig(input int which, input logic val, input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      if ((which == 0 ? drv_step : drv_dir) == val) begin
        at = cyc_no;
        break;
      end
      tick();
    end
  endtask

  task automatic meas_high(output int w);
    w = 0;
    for (int i = 0; i < 200; i++) begin
      if (!drv_step) break;
      w++;
      tick();
    end
  endtask

  task automatic count_rises(input int n, output int c);
    logic prev;
    prev = drv_step;
    c = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (!prev && drv_step) c++;
      prev = drv_step;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r1, r2, r3, r4, r5, r6, f, d, w, c, c0;
    x0 = 12'd1000; x = 16'd0; dx1 = 16'd100; dx2 = 16'd1000;
    F1 = 16'd200; F2 = 16'd1000; k = 20'd32; dz_in = 16'd20; dz_out = 16'd50;

    tick(); tick();
    chk("rst_N", N, 0);
    chk("rst_step", drv_step, 0);
    chk("rst_dir", drv_dir, 0);
    chk("rst_en", drv_enable_SM, 0);
    chk("rst_cnt", step_cnt, 0);
    rst = 1'b0;
    tick();
    chk("idle_N", N, 0);

    // Rate law with the tracker idle
    strobe(16'd900); tick(); chk("n_at_dx1", N, 200);
    strobe(16'd700); tick(); chk("n_linear", N, 600);
    strobe(16'd0);   tick(); chk("n_at_dx2", N, 1000);
    x = 16'd100; data_valid = 1'b1; tick();
    x = 16'd700; tick();
    data_valid = 1'b0;
    chk("n_b2b_first", N, 1800);
    tick(); chk("n_latest_wins", N, 600);
    strobe(16'd500); tick(); chk("n_main", N, 1000);
    chk("idle_en", drv_enable_SM, 0);

    // Enable tracking
    tr_mode_enable = 1'b1;
    tick();
    chk("ena_en", drv_enable_SM, 1);
    chk("ena_dir", drv_dir, 1);
    chk("ena_cnt", step_cnt, 0);
    c0 = cyc_no;
    wait_rise(5, r1);
    chk("first_rise_lat", r1 - c0, 1);
    chk("cnt_after_1", step_cnt, 1);
    meas_high(w);
    chk("pulse_width", w, 50);
    wait_rise(1100, r2);
    chk("period_1000", r2 - r1, 1000);
    chk("cnt_after_2", step_cnt, 2);

    // Saturation and clamp; new period only at next pulse start
    k = 20'hFFFFF;
    strobe(16'd1); tick(); chk("n_saturate", N, 16'hFFFF);
    k = 20'd32; F1 = 16'd10;
    strobe(16'd950); tick(); chk("n_below_dx1", N, 10);
    wait_rise(1100, r3);
    chk("period_old_p", r3 - r2, 1000);
    wait_rise(200, r4);
    chk("period_clamp", r4 - r3, 128);

    // Deadzone hysteresis
    strobe(16'd970); tick(); chk("dz_30_en", drv_enable_SM, 1);
    strobe(16'd980); tick();
    chk("dz_20_en", drv_enable_SM, 0);
    chk("dz_20_step_cut", drv_step, 0);
    strobe(16'd960);
    count_rises(300, c);
    chk("dz_40_no_pulse", c, 0);
    chk("dz_40_en", drv_enable_SM, 0);
    strobe(16'd950); tick();
    chk("dz_50_en", drv_enable_SM, 1);
    tick();
    chk("dz_50_step", drv_step, 1);
    r5 = cyc_no;

    // Sign flip during a pulse
    strobe(16'd1100);
    wait_sig(0, 1'b0, 100, f);
    chk("flip_pulse_full", f - r5, 50);
    wait_sig(1, 1'b0, 300, d);
    chk("flip_dwell", d - f, 100);
    chk("flip_en", drv_enable_SM, 1);
    wait_rise(10, r6);
    chk("flip_resume", r6 - d, 1);

    // Enable dropped mid-pulse
    tick(); tick();
    tr_mode_enable = 1'b0;
    tick();
    chk("drop_step", drv_step, 0);
    chk("drop_en", drv_enable_SM, 0);
    chk("drop_dir_hold", drv_dir, 0);
    count_rises(200, c);
    chk("drop_no_pulse", c, 0);
    tr_mode_enable = 1'b1;
    tick();
    chk("reena_cnt_clr", step_cnt, 0);
    chk("reena_en", drv_enable_SM, 1);
    tick();
    chk("reena_step", drv_step, 1);
    chk("reena_cnt", step_cnt, 1);

    // Asynchronous reset mid-pulse
    #3;
    rst = 1'b1;
    #1;
    chk("arst_step", drv_step, 0);
    chk("arst_en", drv_enable_SM, 0);
    chk("arst_dir", drv_dir, 0);
    chk("arst_N", N, 0);
    chk("arst_cnt", step_cnt, 0);
    tr_mode_enable = 1'b0;
    tick();
    rst = 1'b0;
    tick(); tick();
    chk("post_rst_en", drv_enable_SM, 0);
    tr_mode_enable = 1'b1;
    tick();
    chk("post_rst_leave_idle", drv_enable_SM, 1);
    tick();
    chk("post_rst_dz_en", drv_enable_SM, 0);
    chk("post_rst_dz_step", drv_step, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tr_step_tracker.md
# tr_step_tracker

Parametrised tracking-mode stepper controller: samples a position word on each ADC strobe, computes the error against a table target, derives a step period from a piecewise-linear law, and generates the step, direction and enable signals for the stepper driver. It adds deadzone hysteresis, a direction-change dwell and an internal step-pulse generator. It sits between the ADC reader and the stepper driver pins.

## Interface
- WIDTH_IN, 12: width of target x0.
- WIDTH_WORK, 16: width of x, dx, dx1, dx2, F1, F2, N and step_cnt.
- K_WIDTH, 20: width of slope k.
- FRAC_BITS, 4: fractional bits of k; the product is shifted right by this amount.
- N_MIN, 128: minimum step period in clk cycles. N below this value is clamped to it.
- PULSE_WIDTH, 50: drv_step high time in clk cycles. Must be less than N_MIN.
- DIR_SETUP, 100: idle cycles between the last pulse and a drv_dir change.
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-high reset.
- data_valid  in  1  one-cycle strobe, synchronous to clk; a new x is present.
- tr_mode_enable  in  1  tracking mode request.
- x0  in  WIDTH_IN  target position; zero-extended to WIDTH_WORK.
- x  in  WIDTH_WORK  measured position.
- dx1, dx2  in  WIDTH_WORK  breakpoints of the rate law; dx1 ≤ dx2.
- F1, F2  in  WIDTH_WORK  periods at and below dx1, and at and above dx2.
- k  in  K_WIDTH  slope between the breakpoints, unsigned, with FRAC_BITS fractional bits.
- dz_in, dz_out  in  WIDTH_WORK  deadzone entry and exit thresholds; dz_in < dz_out.
- N  out  WIDTH_WORK  current step period in clk cycles. Reset value 0.
- drv_step  out  1  step pulse. Reset value 0.
- drv_dir  out  1  1 when x ≤ x0, 0 when x > x0. Reset value 0.
- drv_enable_SM  out  1  driver enable. Reset value 0.
- step_cnt  out  WIDTH_WORK  pulses issued since leaving IDLE; wraps. Reset value 0.

## Operation
- Stage 1, on a data_valid cycle:
  - If x ≤ x0: dx_r = x0 − x and sgn_r = 1.
  - Otherwise: dx_r = x − x0 and sgn_r = 0.
  - dx_r and sgn_r hold between strobes.
- Stage 2, in the cycle after stage 1 updates:
  - dx_r ≥ dx2: N = F2. This check has priority.
  - dx1 ≤ dx_r < dx2: N = F1 + ((k·(dx_r−dx1)) >> FRAC_BITS). The product is K_WIDTH+WIDTH_WORK bits. The sum saturates at 2^WIDTH_WORK−1.
  - dx_r < dx1: N = F1.
- Effective period: P = max(N, N_MIN).
- FSM states: IDLE, TO_ZERO, IN_DZ, DIR_CHANGE.
- IDLE:
  - drv_enable_SM = 0 and no pulses are issued.
  - tr_mode_enable = 1 → clear step_cnt, load drv_dir = sgn_r, set drv_enable_SM = 1, go to TO_ZERO.
- TO_ZERO:
  - Pulses are issued with period P.
  - dx_r ≤ dz_in → go to IN_DZ and set drv_enable_SM = 0.
  - Otherwise, sgn_r ≠ drv_dir → go to DIR_CHANGE.
- IN_DZ:
  - No pulses are issued.
  - dx_r ≥ dz_out → set drv_enable_SM = 1. Go to TO_ZERO if sgn_r = drv_dir, otherwise to DIR_CHANGE.
  - Values between dz_in and dz_out give hysteresis: no chatter.
- DIR_CHANGE:
  - No new pulses start. Any in-flight pulse completes its full PULSE_WIDTH.
  - After the pulse ends, wait DIR_SETUP cycles, load drv_dir = sgn_r, go to TO_ZERO.
- tr_mode_enable = 0 in any state → IDLE on the next clock. drv_step and drv_enable_SM are forced to 0 immediately, truncating any pulse. drv_dir holds.
- rst, at any time, asynchronously clears the FSM to IDLE, all counters, dx_r, sgn_r and every output to its reset value.
- Pulse generator:
  - The period counter reloads with the current P at each pulse start.
  - A change in N takes effect at the next pulse start.
  - step_cnt increments on each drv_step rising edge.

## Timing
- A data_valid at cycle t gives:
  - dx_r and sgn_r valid at t+1;
  - N valid at t+2;
  - FSM transitions caused by the sample registered at the clk edge ending cycle t+1, with the new state visible at t+2.
- Entering TO_ZERO at cycle s: the first drv_step rises at s+1. Later rising edges are P cycles apart. Each pulse is high for exactly PULSE_WIDTH cycles.
- Leaving TO_ZERO for IN_DZ: drv_step drops at once, and no further pulse starts.
- DIR_CHANGE: drv_dir changes exactly DIR_SETUP cycles after the falling edge of the last pulse, or after DIR_CHANGE entry if no pulse was high. The next pulse starts on the following cycle.
- data_valid in consecutive cycles: each strobe is processed and the latest sample wins.

## Test plan
- Reset mid-pulse: assert rst while drv_step = 1 → all outputs are 0 asynchronously; after release, FSM is IDLE.
- x0=1000, x=500, dx1=100, dx2=1000, F1=200, F2=1000, k=32 (2.0), tr_mode_enable=1 → dx_r=500, N=1000, drv_dir=1, pulses 50 cycles wide, rising edges 1000 cycles apart.
- Linear-region overflow: dx_r near dx2 with k=0xFFFFF → N saturates to 0xFFFF. Clamp: F1=10 with dx_r < dx1 → pulses 128 cycles apart.
- Hysteresis with dz_in=20, dz_out=50: dx_r steps 30→20 → IN_DZ and drv_enable_SM=0. dx_r=40 → stays in IN_DZ. dx_r=50 → back to TO_ZERO and drv_enable_SM=1.
- Error sign flip (x: 900→1100, x0=1000) during a pulse → the pulse completes, drv_dir goes 1→0 exactly 100 cycles after its falling edge, and pulses resume.
- tr_mode_enable dropped mid-pulse → drv_step and drv_enable_SM are 0 next cycle and FSM is IDLE. Re-enabling clears step_cnt to 0.
